// File: rtl/fighter_anim_sprite_pkg.sv
// Shared types and constants for the fighter sprite renderer.
package fighter_sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } anim_state_t;

    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;
    localparam int DEF_TRANSP_IDX = 0;

    // Texel count of one animation frame in ROM.
    function automatic int frame_size(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/fighter_anim_sprite_if.sv
// Pixel-path bus: scan position and sprite placement in, ROM port and pixel out.
interface fighter_anim_sprite_if #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 4
);
    logic [9:0]        DrawX, DrawY;
    logic [9:0]        PosX, PosY;
    logic              blank;
    logic              flip_h;
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pix_idx;
    logic              sprite_on;

    modport master (
        output DrawX, DrawY, PosX, PosY, blank, flip_h, rom_q,
        input  rom_addr, pix_idx, sprite_on
    );

    modport slave (
        input  DrawX, DrawY, PosX, PosY, blank, flip_h, rom_q,
        output rom_addr, pix_idx, sprite_on
    );
endinterface

// File: rtl/fighter_anim_sprite_ctrl.sv
// Animation sequencer: frame stepping on frame_start, with looping or one-shot stop.
module sprite_anim_ctrl
    import fighter_sprite_pkg::*;
#(
    parameter int SPR_W      = 70,
    parameter int SPR_H      = 120,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    parameter int ADDR_W     = 16,
    parameter int FI_W       = 2
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              start,
    input  logic              loop_en,
    output logic              anim_done,
    output logic [FI_W-1:0]   frame_idx,
    output logic [ADDR_W-1:0] frame_base
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_DONE = DONE;

    localparam int                HC_W       = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HC_W-1:0]   HOLD_LAST  = HC_W'(FRAME_HOLD - 1);
    localparam logic [FI_W-1:0]   LAST_FRAME = FI_W'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0] FSZ        = ADDR_W'(frame_size(SPR_W, SPR_H));

    logic [1:0]      state;
    logic [HC_W-1:0] hold_cnt;

    // start overrides everything (including a coincident frame_start); frame base
    // is stepped by addition so no multiplier sits on the address path.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            frame_idx  <= '0;
            frame_base <= '0;
            anim_done  <= 1'b0;
        end else if (start) begin
            state      <= ST_PLAY;
            hold_cnt   <= '0;
            frame_idx  <= '0;
            frame_base <= '0;
            anim_done  <= 1'b0;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (frame_start) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            if (frame_idx < LAST_FRAME) begin
                                frame_idx  <= frame_idx + 1'b1;
                                frame_base <= frame_base + FSZ;
                            end else if (loop_en) begin
                                frame_idx  <= '0;
                                frame_base <= '0;
                            end else begin
                                state     <= ST_DONE;
                                anim_done <= 1'b1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state      <= ST_IDLE;
                    frame_idx  <= '0;
                    frame_base <= '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/fighter_anim_sprite.sv
// Fighter sprite renderer: box test, scaled/flipped ROM addressing, 3-cycle pixel
// pipeline with index-keyed transparency. Optional SPRITE_BLINK_EN adds hit_flash
// blinking (sprite hidden 4 of every 8 frames while hit_flash is held).
module fighter_anim_sprite
    import fighter_sprite_pkg::*;
#(
    parameter int SPR_W      = 70,
    parameter int SPR_H      = 120,
    parameter int SCALE_LOG2 = 1,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    parameter int ADDR_W     = 16,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = DEF_TRANSP_IDX,
    localparam int FI_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    fighter_anim_sprite_if.slave  bus,
    input  logic                  frame_start,
    input  logic                  start,
    input  logic                  loop_en,
`ifdef SPRITE_BLINK_EN
    input  logic                  hit_flash,
`endif
    output logic                  anim_done,
    output logic [FI_W-1:0]       frame_idx
);
    logic [ADDR_W-1:0] frame_base;

    sprite_anim_ctrl #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES),
        .FRAME_HOLD(FRAME_HOLD), .ADDR_W(ADDR_W), .FI_W(FI_W)
    ) u_ctrl (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
        .start(start), .loop_en(loop_en), .anim_done(anim_done),
        .frame_idx(frame_idx), .frame_base(frame_base)
    );

    // 11-bit operands so a box crossing the screen edge clips rather than wraps.
    logic [10:0]       x11, y11, px11, py11, dx, dy, col, row, col_f;
    logic              in_box;
    logic [ADDR_W-1:0] addr_c;

    assign x11    = {1'b0, bus.DrawX};
    assign y11    = {1'b0, bus.DrawY};
    assign px11   = {1'b0, bus.PosX};
    assign py11   = {1'b0, bus.PosY};
    assign in_box = (x11 >= px11) && (x11 < px11 + 11'(SPR_W << SCALE_LOG2)) &&
                    (y11 >= py11) && (y11 < py11 + 11'(SPR_H << SCALE_LOG2));
    assign dx     = x11 - px11;
    assign dy     = y11 - py11;
    assign col    = dx >> SCALE_LOG2;
    assign row    = dy >> SCALE_LOG2;
    assign col_f  = bus.flip_h ? (11'(SPR_W - 1) - col) : col;
    assign addr_c = in_box ? (frame_base + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_f)) : '0;

    logic blink_hide;
`ifdef SPRITE_BLINK_EN
    logic [2:0] blink_cnt;

    // Counts frames while flashing; restarts from zero each time a flash begins.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)         blink_cnt <= '0;
        else if (!hit_flash)  blink_cnt <= '0;
        else if (frame_start) blink_cnt <= blink_cnt + 3'd1;
    end
    assign blink_hide = hit_flash && blink_cnt[2];
`else
    assign blink_hide = 1'b0;
`endif

    // vld_d[k]: pixel was inside the box during active video, k cycles ago.
    logic [2:1] vld_d;

    // Stage 1/2: register ROM address, carry visibility alongside the ROM read.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rom_addr <= '0;
            vld_d        <= '0;
        end else begin
            bus.rom_addr <= addr_c;
            vld_d[1]     <= in_box && bus.blank;
            vld_d[2]     <= vld_d[1];
        end
    end

    logic opaque;
    assign opaque = vld_d[2] && (bus.rom_q != IDX_W'(TRANSP_IDX)) && !blink_hide;

    // Stage 3: register pixel; index forced to 0 whenever the sprite is not drawn.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.sprite_on <= 1'b0;
            bus.pix_idx   <= '0;
        end else begin
            bus.sprite_on <= opaque;
            bus.pix_idx   <= opaque ? bus.rom_q : '0;
        end
    end
endmodule

// File: tb/tb_fighter_anim_sprite.sv
// Directed bench for fighter_anim_sprite with an expected-pixel scoreboard queue.
module tb_fighter_anim_sprite;
    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       frame_start = 1'b0;
    logic       start = 1'b0;
    logic       loop_en = 1'b0;
    logic       anim_done;
    logic [1:0] frame_idx;
`ifdef SPRITE_BLINK_EN
    logic       hit_flash = 1'b0;
`endif

    fighter_anim_sprite_if #(.ADDR_W(16), .IDX_W(4)) bus ();

    fighter_anim_sprite dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .bus(bus),
        .frame_start(frame_start), .start(start), .loop_en(loop_en),
`ifdef SPRITE_BLINK_EN
        .hit_flash(hit_flash),
`endif
        .anim_done(anim_done), .frame_idx(frame_idx)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic       on;
        logic [3:0] idx;
    } exp_t;

    exp_t sbq[$];
    int   ncomp = 0;
    int   nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // Drive one held scan position; model the expected address and pixel independently.
    task automatic pixel(input string tag, input int x, input int y, input logic bl,
                         input logic [3:0] q, input int frame);
        int   px, py, col, row, ea;
        logic inb;
        exp_t e, got;
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.blank = bl;
        bus.rom_q = q;
        px  = int'(bus.PosX);
        py  = int'(bus.PosY);
        inb = (x >= px) && (x < px + 140) && (y >= py) && (y < py + 240);
        col = (x - px) / 2;
        row = (y - py) / 2;
        if (bus.flip_h) col = 69 - col;
        ea  = inb ? (frame * 8400 + row * 70 + col) : 0;
        e.on  = inb && bl && (q != 4'd0);
        e.idx = e.on ? q : 4'd0;
        sbq.push_back(e);
        tick();
        chk({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(ea));
        tick();
        tick();
        got = sbq.pop_front();
        chk({tag, ".sprite_on"}, 32'(bus.sprite_on), 32'(got.on));
        chk({tag, ".pix_idx"}, 32'(bus.pix_idx), 32'(got.idx));
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bus.DrawX = '0; bus.DrawY = '0; bus.PosX = '0; bus.PosY = '0;
        bus.blank = 1'b0; bus.flip_h = 1'b0; bus.rom_q = '0;

        // Reset state, asserted before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst.rom_addr", 32'(bus.rom_addr), 0);
        chk("rst.sprite_on", 32'(bus.sprite_on), 0);
        chk("rst.pix_idx", 32'(bus.pix_idx), 0);
        chk("rst.anim_done", 32'(anim_done), 0);
        chk("rst.frame_idx", 32'(frame_idx), 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Idle rendering at sprite origin and one pixel left of it.
        bus.PosX = 10'd100; bus.PosY = 10'd50;
        pixel("idle_in", 100, 50, 1'b1, 4'd5, 0);
        pixel("idle_left", 99, 50, 1'b1, 4'd5, 0);

        // Scale and flip addressing.
        pixel("scale", 102, 53, 1'b1, 4'd3, 0);
        bus.flip_h = 1'b1;
        pixel("flip", 102, 53, 1'b1, 4'd3, 0);
        pixel("flip_corner", 239, 289, 1'b1, 4'd15, 0);
        bus.flip_h = 1'b0;
        pixel("box_right_out", 240, 60, 1'b1, 4'd4, 0);
        pixel("box_bottom_out", 120, 290, 1'b1, 4'd4, 0);

        // Transparency and blanking.
        pixel("transp", 110, 60, 1'b1, 4'd0, 0);
        pixel("blanked", 110, 60, 1'b0, 4'd7, 0);

        // One-shot animation: 6 pulses per frame, done after pulse 24.
        loop_en = 1'b0;
        pulse_start();
        tick();
        chk("play.frame0", 32'(frame_idx), 0);
        for (int p = 1; p <= 24; p++) begin
            pulse_fs();
            if (p % 6 == 0 && p < 24) chk("play.frame_step", 32'(frame_idx), 32'(p / 6));
            if (p == 6) pixel("frame1_base", 100, 50, 1'b1, 4'd2, 1);
            if (p == 23) chk("play.not_done", 32'(anim_done), 0);
        end
        chk("play.done", 32'(anim_done), 1);
        chk("play.last_frame", 32'(frame_idx), 3);
        pulse_fs();
        chk("done.hold_frame", 32'(frame_idx), 3);

        // Looping animation wraps back to frame 0.
        loop_en = 1'b1;
        pulse_start();
        tick();
        chk("loop.done_clear", 32'(anim_done), 0);
        for (int p = 1; p <= 24; p++) pulse_fs();
        chk("loop.wrap", 32'(frame_idx), 0);
        chk("loop.not_done", 32'(anim_done), 0);

        // start coincident with frame_start on the would-be advancing pulse.
        for (int p = 1; p <= 5; p++) pulse_fs();
        start = 1'b1; frame_start = 1'b1;
        tick();
        start = 1'b0; frame_start = 1'b0;
        tick();
        chk("coll.frame", 32'(frame_idx), 0);
        for (int p = 1; p <= 5; p++) pulse_fs();
        chk("coll.hold_restart", 32'(frame_idx), 0);
        pulse_fs();
        chk("coll.advance", 32'(frame_idx), 1);

        // Right-edge clipping at frame 1.
        bus.PosX = 10'd600; bus.PosY = 10'd50;
        pixel("edge_639", 639, 60, 1'b1, 4'd9, 1);
        pixel("edge_wrap0", 0, 60, 1'b1, 4'd9, 1);

        // Asynchronous reset mid-PLAY with an opaque pixel on the output.
        pixel("pre_reset", 610, 60, 1'b1, 4'd6, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("areset.sprite_on", 32'(bus.sprite_on), 0);
        chk("areset.pix_idx", 32'(bus.pix_idx), 0);
        chk("areset.rom_addr", 32'(bus.rom_addr), 0);
        chk("areset.frame_idx", 32'(frame_idx), 0);
        chk("areset.anim_done", 32'(anim_done), 0);
        tick();
        reset_n = 1'b1;
        tick();
        for (int p = 1; p <= 6; p++) pulse_fs();
        chk("idle.no_advance", 32'(frame_idx), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule

// File: doc/fighter_anim_sprite.md
Name: fighter_anim_sprite

Overview:
Parametrised fighter sprite renderer with multi-frame animation, integer upscaling, horizontal flip and index-keyed transparency.
- Sits between the VGA controller (DrawX/DrawY/blank) and the shared palette/colour mux.
- Drives a synchronous external sprite ROM and emits a palette index plus a sprite_on flag.
- Animation advances only on frame_start, so a frame never tears mid-scan.

Parameters:
SPR_W, 70, sprite width in ROM texels
SPR_H, 120, sprite height in ROM texels
SCALE_LOG2, 1, on-screen scale = 2^SCALE_LOG2 (1 gives 140x240)
NUM_FRAMES, 4, animation frames stored back-to-back in ROM
FRAME_HOLD, 6, frame_start pulses each animation frame is held
ADDR_W, 16, ROM address width; must be >= clog2(NUM_FRAMES*SPR_W*SPR_H)
IDX_W, 4, palette index width
TRANSP_IDX, 0, index treated as transparent

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
reset_n  in  1  asynchronous, active-low reset
DrawX, DrawY  in  10  current scan position
PosX, PosY  in  10  sprite top-left on screen
blank  in  1  1 = active video
frame_start  in  1  one-cycle pulse at start of vertical blank
start  in  1  one-cycle pulse: restart animation at frame 0
loop_en  in  1  1 = wrap after last frame, 0 = stop on last frame
flip_h  in  1  1 = mirror horizontally (sprite faces left)
rom_addr  out  ADDR_W  registered ROM address
rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr
pix_idx  out  IDX_W  palette index, registered
sprite_on  out  1  registered: opaque sprite pixel at this position
anim_done  out  1  level: non-looping animation finished
frame_idx  out  clog2(NUM_FRAMES)  current frame, for debug and game logic

Behaviour:
Reset:
- rom_addr=0, pix_idx=0, sprite_on=0, anim_done=0, frame_idx=0, hold_cnt=0.
- FSM enters IDLE.
- Applies immediately and asynchronously, including mid-line.

Box test:
- in_box = DrawX>=PosX && DrawX<PosX+(SPR_W<<SCALE_LOG2), and the same for Y with SPR_H.
- Comparisons use 11-bit operands, so a sprite overlapping x=639 or y=479 clips instead of wrapping.

Address:
- col = (DrawX-PosX)>>SCALE_LOG2; row = (DrawY-PosY)>>SCALE_LOG2.
- If flip_h, col' = SPR_W-1-col; otherwise col' = col.
- rom_addr = frame_base + row*SPR_W + col'.
- Outside the box, rom_addr = 0.
- frame_base is a register stepped by SPR_W*SPR_H; no multiply by the frame index.

Pipeline (total latency 3 cycles from DrawX to output):
- Cycle N+1: rom_addr registered. in_box and blank are delayed alongside it.
- Cycle N+2: rom_q is valid.
- Cycle N+3: pix_idx <= rom_q; sprite_on <= blank_d2 && in_box_d2 && rom_q!=TRANSP_IDX.
- When sprite_on=0, pix_idx=0.
- Callers offset PosX by -3 if pixel-exact alignment is needed.

FSM: IDLE, PLAY, DONE.
- IDLE: frame_idx=0. On start -> PLAY with hold_cnt=0.
- PLAY: on each frame_start, hold_cnt++. When hold_cnt==FRAME_HOLD-1 on a frame_start:
  - clear hold_cnt;
  - if frame_idx<NUM_FRAMES-1, frame_idx++ and frame_base += frame size;
  - else if loop_en, frame_idx=0 and frame_base=0;
  - else -> DONE.
- DONE: frame_idx holds NUM_FRAMES-1; anim_done=1. On start -> PLAY at frame 0 and anim_done clears.

Simultaneous events and edge cases:
- start and frame_start in the same cycle: start wins, hold_cnt=0, and this frame_start is not counted.
- FRAME_HOLD=1 advances the frame on every frame_start.
- NUM_FRAMES=1 with loop_en holds frame 0 indefinitely.
- flip_h and PosX are sampled per pixel; changing them mid-frame is the caller's responsibility.

Optional Feature:
SPRITE_BLINK_EN
- Defined: adds input hit_flash (1 bit) and an internal 3-bit counter of frame_start pulses.
  - While hit_flash=1, sprite_on is forced to 0 whenever counter bit 2 = 1 (invisible 4 of every 8 frames).
  - The counter clears on reset_n and when hit_flash=0.
- Undefined: no hit_flash port and no counter; behaviour is exactly as above.

Decomposition:
Package fighter_sprite_pkg holds:
- the anim_state_t enum (IDLE/PLAY/DONE);
- SCREEN_W=640 and SCREEN_H=480;
- the default TRANSP_IDX;
- function frame_size(w,h).

One sub-module, sprite_anim_ctrl, holds the FSM, hold_cnt, frame_idx, frame_base and anim_done. The parent holds the address and pixel pipeline.

Test Plan:
- Reset + idle: PosX=100, PosY=50, DrawX=100, DrawY=50, blank=1, rom_q=5 -> 3 cycles later sprite_on=1, pix_idx=5, rom_addr had been 0; DrawX=99 -> sprite_on=0.
- Scale/flip: DrawX=PosX+2, DrawY=PosY+3, SCALE_LOG2=1 -> rom_addr=1*70+1=71; with flip_h=1 -> rom_addr=70+68=138.
- Transparency: rom_q=TRANSP_IDX=0 inside box -> sprite_on=0, pix_idx=0; blank=0 with rom_q=7 -> sprite_on=0.
- Animation non-loop: start, then 24 frame_start pulses, loop_en=0 -> frame_idx steps 0,1,2,3 every 6 pulses; after pulse 24 anim_done=1, frame_idx=3; frame-1 base = 8400.
- Loop + collision: loop_en=1, 24 pulses -> frame_idx=0; start coincident with frame_start -> frame_idx=0, hold_cnt=0.
- Edge clip and reset: PosX=600, DrawX=639 -> in box; DrawX wraps to 0 -> sprite_on=0. Assert reset_n=0 mid-PLAY -> all outputs 0 asynchronously, FSM IDLE.
